// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential restoring divider:
//   - div_state_t : controller states (FIX is only reachable when the
//                   DIV_SIGNED_EN macro is defined)
//   - DIV_W       : default operand width
//   - cnt_width() : width of an iteration counter that must hold 0..n-1
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Bits needed to count down from n-1 to 0 (never less than one bit).
  function automatic int cnt_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/seq_divider_step.sv
// -----------------------------------------------------------------------------
// div_step
// One restoring-division step, purely combinational.
// Ports:
//   p_i   [W:0]   current partial remainder
//   bit_i         next dividend bit shifted into the partial remainder
//   d_i   [W-1:0] divisor magnitude
//   p_o   [W:0]   partial remainder after the step
//   q_o           quotient bit produced by the step
// -----------------------------------------------------------------------------
module div_step
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic [W:0]   p_i,
  input  logic         bit_i,
  input  logic [W-1:0] d_i,
  output logic [W:0]   p_o,
  output logic         q_o
);

  logic [W:0] t_s;
  logic [W:0] d_ext_s;

  assign t_s     = {p_i[W-1:0], bit_i};
  assign d_ext_s = {1'b0, d_i};

  // Trial subtraction. If p_i[W] were ever set the true shifted value would
  // exceed any W-bit divisor, so it forces the subtract path.
  always_comb begin
    if (p_i[W] || (t_s >= d_ext_s)) begin
      p_o = t_s - d_ext_s;
      q_o = 1'b1;
    end else begin
      p_o = t_s;
      q_o = 1'b0;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Sequential restoring divider: 2W-bit dividend / W-bit divisor, one quotient
// bit per clock, start/done handshake.
// Optional macro DIV_SIGNED_EN adds a signed_op input and a FIX state that
// restores signs after the magnitude division.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   request pulse, sampled only while busy is low
//   dividend   in   [2W-1:0] numerator, captured on accepted start
//   divisor    in   [W-1:0]  denominator, captured on accepted start
//   signed_op  in   two's complement operands (DIV_SIGNED_EN only)
//   busy       out  high from the cycle after start through the done cycle
//   done       out  single-cycle result-valid pulse
//   quotient   out  [2W-1:0] result, held until the next accepted start
//   remainder  out  [W-1:0]  result, held until the next accepted start
//   dbz        out  divide-by-zero flag, held with the results
// -----------------------------------------------------------------------------
module seq_divider
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
`ifdef DIV_SIGNED_EN
  input  logic           signed_op,
`endif
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] quotient,
  output logic [W-1:0]   remainder,
  output logic           dbz
);

  localparam int            CW       = cnt_width(2 * W);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  div_state_t     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W:0]     p_q, p_d;
  logic [2*W-1:0] q_q, q_d;
  logic [W-1:0]   dv_q, dv_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           dbz_q, dbz_d;
  logic [2*W-1:0] quot_q, quot_d;
  logic [W-1:0]   rem_q, rem_d;

  logic [W:0]     step_p_s;
  logic           step_bit_s;
  logic [2*W-1:0] dd_mag_s;
  logic [W-1:0]   dv_mag_s;
  logic           go_fix_s;

`ifdef DIV_SIGNED_EN
  logic sgn_q, sgn_d;
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;
  logic dd_neg_s, dv_neg_s;

  assign dd_neg_s = signed_op & dividend[2*W-1];
  assign dv_neg_s = signed_op & divisor[W-1];
  assign dd_mag_s = dd_neg_s ? (-dividend) : dividend;
  assign dv_mag_s = dv_neg_s ? (-divisor) : divisor;
  assign go_fix_s = sgn_q;
`else
  assign dd_mag_s = dividend;
  assign dv_mag_s = divisor;
  assign go_fix_s = 1'b0;
`endif

  div_step #(.W(W)) u_step (
    .p_i   (p_q),
    .bit_i (q_q[2*W-1]),
    .d_i   (dv_q),
    .p_o   (step_p_s),
    .q_o   (step_bit_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (divisor == {W{1'b0}}) ? DONE : CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_d = go_fix_s ? FIX : DONE;
        end else begin
          state_d = CALC;
        end
      end
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output register next values.
  always_comb begin
    cnt_d  = cnt_q;
    p_d    = p_q;
    q_d    = q_q;
    dv_d   = dv_q;
    busy_d = busy_q;
    done_d = 1'b0;
    quot_d = quot_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
`ifdef DIV_SIGNED_EN
    sgn_d     = sgn_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          dv_d   = dv_mag_s;
          q_d    = dd_mag_s;
          p_d    = {(W+1){1'b0}};
          cnt_d  = CNT_LAST;
`ifdef DIV_SIGNED_EN
          sgn_d     = signed_op;
          neg_quo_d = dd_neg_s ^ dv_neg_s;
          neg_rem_d = dd_neg_s;
`endif
          if (divisor == {W{1'b0}}) begin
            quot_d = {(2*W){1'b1}};
            rem_d  = {W{1'b0}};
            dbz_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            done_d = 1'b0;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      CALC: begin
        p_d = step_p_s;
        q_d = {q_q[2*W-2:0], step_bit_s};
        if (cnt_q == {CW{1'b0}}) begin
          // Last step: publish directly unless a sign fix-up cycle follows.
          if (!go_fix_s) begin
            quot_d = {q_q[2*W-2:0], step_bit_s};
            rem_d  = step_p_s[W-1:0];
            dbz_d  = 1'b0;
            done_d = 1'b1;
          end else begin
            done_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      FIX: begin
`ifdef DIV_SIGNED_EN
        quot_d = neg_quo_q ? (-q_q) : q_q;
        rem_d  = neg_rem_q ? (-p_q[W-1:0]) : p_q[W-1:0];
        dbz_d  = 1'b0;
        done_d = 1'b1;
`else
        // Unreachable without signed support.
        done_d = 1'b0;
`endif
      end
      DONE: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_d_reset();
    end else begin
      cnt_q  <= cnt_d;
      p_q    <= p_d;
      q_q    <= q_d;
      dv_q   <= dv_d;
      busy_q <= busy_d;
      done_q <= done_d;
      dbz_q  <= dbz_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
    end
  end

  // Reset values for the datapath registers, kept in one place.
  task automatic cnt_d_reset();
    cnt_q  <= {CW{1'b0}};
    p_q    <= {(W+1){1'b0}};
    q_q    <= {(2*W){1'b0}};
    dv_q   <= {W{1'b0}};
    busy_q <= 1'b0;
    done_q <= 1'b0;
    dbz_q  <= 1'b0;
    quot_q <= {(2*W){1'b0}};
    rem_q  <= {W{1'b0}};
  endtask

`ifdef DIV_SIGNED_EN
  // Sign bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      sgn_q     <= sgn_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign dbz       = dbz_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring divider; the inverse operation of the team's 5x5 Wallace-tree multiplier datapath.
- Takes a 2W-bit dividend, the width of a WxW product, and a W-bit divisor.
- Produces a 2W-bit quotient and a W-bit remainder, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic unit, behind a start/done handshake.

Parameters:
- W, 5: operand width. Dividend and quotient are 2W bits; divisor and remainder are W bits.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request pulse; sampled only when busy=0.
- dividend  in  2W  numerator; captured on the accepted start.
- divisor  in  W  denominator; captured on the accepted start.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- done  out  1  single-cycle pulse; results are valid from this cycle.
- quotient  out  2W  result, held until the next accepted start.
- remainder  out  W  result, held until the next accepted start.
- dbz  out  1  divide-by-zero flag, held with the results.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy, done, dbz = 0; quotient, remainder = 0; iteration counter = 0. Reset mid-operation aborts the division immediately; no done is produced.
- States: IDLE, CALC, DONE (plus FIX when DIV_SIGNED_EN is defined).
- IDLE, start=1:
  - Capture the operands.
  - If divisor != 0: next state CALC, counter = 2W-1, partial remainder P = 0 (W+1 bits), shift register Q = dividend.
  - If divisor == 0: next state DONE directly.
- CALC, each cycle:
  - T = {P[W-1:0], Q[2W-1]}.
  - If T >= {1'b0, divisor}: P = T - divisor and the new quotient LSB = 1. Otherwise P = T and the new quotient LSB = 0.
  - Q shifts left one bit, taking in the new quotient LSB.
  - At counter == 0, go to DONE; otherwise decrement the counter.
- DONE, one cycle:
  - done=1, busy=1. Registered outputs update on entering DONE.
  - Normal case: quotient = Q, remainder = P[W-1:0], dbz = 0.
  - Divide by zero: quotient = all ones, remainder = 0, dbz = 1.
  - Next state IDLE. busy=0 in IDLE.
- Latency, counting the accepted-start edge as cycle 0:
  - Normal case: done in cycle 2W+1 (11 for W=5).
  - Divide by zero: done in cycle 1.
- start while busy=1 (CALC/DONE) is ignored; no queueing.
- start in the cycle after DONE (IDLE) is accepted, so back-to-back operation costs no gap beyond DONE.
- Boundary values:
  - divisor=1 gives quotient = dividend, remainder = 0.
  - dividend < divisor gives quotient = 0, remainder = dividend[W-1:0].
  - Maximum dividend 2^(2W)-1 must not overflow P. P carries W+1 bits for this.
- Outputs are glitch-free registers; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro DIV_SIGNED_EN.
- Defined:
  - Adds input port signed_op (1 bit), captured with start.
  - With signed_op=1, operands are two's complement. Magnitudes are divided as above.
  - State FIX (one cycle, between CALC and DONE) negates the quotient if the operand signs differ, and negates the remainder if the dividend is negative. Quotient truncates toward zero.
  - Normal-case latency becomes 2W+2.
  - Divide by zero gives the same result as in unsigned mode.
  - With signed_op=0, behaviour and latency are identical to the unsigned build.
- Undefined: no signed_op port, no FIX state, unsigned only.

Decomposition:
- Package div_pkg holds:
  - div_state_t enum (IDLE, CALC, FIX, DONE).
  - Default width constant DIV_W = 5.
  - Function clog2-based counter-width helper.
- One sub-module, div_step: purely combinational single restoring step.
  - Inputs: P, incoming bit, divisor.
  - Outputs: next P, quotient bit.
  - Instantiated once inside seq_divider.

Test Plan:
- W=5, dividend=100, divisor=7 -> done at cycle 11; quotient=14, remainder=2, dbz=0; busy high in cycles 1-11.
- dividend=1023, divisor=31 -> quotient=33, remainder=0. Then dividend=3, divisor=9 -> quotient=0, remainder=3.
- dividend=5, divisor=0 -> done at cycle 1; quotient=1023, remainder=0, dbz=1.
- start re-asserted during CALC with different operands is ignored and the result equals the first request. start in the cycle after done is accepted, and the second done arrives 11 cycles later.
- rst_n pulled low at cycle 6 of a division -> busy, done, outputs go to 0 immediately; no done follows. A fresh start after release completes correctly.
- DIV_SIGNED_EN defined, signed_op=1, dividend=-100, divisor=7 -> done at cycle 12; quotient=-14, remainder=-2. Same operands with signed_op=0 -> unsigned result (924/7: quotient=132, remainder=0).
